// File: rtl/full_st1_data_tx_pkg.sv
// Shared types for the stage-1 data transmitter: float_24_8 word type, FIFO depth, FSM states.
package full_st1_data_tx_pkg;

    typedef logic [31:0] float_24_8;

    localparam int FULL_ST1_TX_DEPTH = 16;
    localparam int LEN_W             = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

    // cfg_length encodes L-1, so 4'hF means a 16-word vector
    function automatic logic [LEN_W-1:0] cfg_to_len(input logic [3:0] cfg);
        return {1'b0, cfg} + 5'd1;
    endfunction

endpackage

// File: rtl/full_st1_data_tx_fifo.sv
// Word storage for full_st1_data_tx: one write port, show-ahead read of head and head+1, occupancy.
module full_st1_data_tx_fifo
    import full_st1_data_tx_pkg::*;
#(
    parameter int  DEPTH = FULL_ST1_TX_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  float_24_8        i_wr_data,
    input  logic             i_rd_en,
    output float_24_8        o_rd_head,
    output float_24_8        o_rd_next,
    output logic [CNT_W-1:0] o_count
);

    float_24_8        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_rptr_inc;

    assign w_rptr_inc = r_rptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_wr_en) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (i_rd_en) begin
                r_rptr <= w_rptr_inc;
            end
            case ({i_wr_en, i_rd_en})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_head = r_mem[r_rptr];
    assign o_rd_next = r_mem[w_rptr_inc];
    assign o_count   = r_count;

endmodule

// File: rtl/full_st1_data_tx.sv
// Buffers upstream words and emits them as whole L-word vectors with a first-word marker.
// Optional vector counter enabled by defining FULL_ST1_DATA_TX_CNT_EN.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | output empty, waiting for at least L words in the FIFO
//   ST_SEND | output register holds a word of the current vector
module full_st1_data_tx
    import full_st1_data_tx_pkg::*;
#(
    parameter int DEPTH = FULL_ST1_TX_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  float_24_8   in_data,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic [3:0]  cfg_length,
    output float_24_8   stage_1_data,
    output logic        stage_1_data_fst,
    output logic        stage_1_data_vld,
    input  logic        stage_1_data_rdy,
    output logic        busy,
    output logic [15:0] vec_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    tx_state_e        r_state;
    tx_state_e        w_state_nxt;
    float_24_8        r_data;
    logic             r_fst;
    logic             r_vld;
    logic [LEN_W-1:0] r_rem;

    logic [CNT_W-1:0] w_occ;
    float_24_8        w_head;
    float_24_8        w_next;
    logic [LEN_W-1:0] w_cfg_len;
    logic             w_wr_en;
    logic             w_beat;
    logic             w_last;
    logic             w_occ_ge_len;
    logic             w_occ_gt_len;
    logic             w_load;
    logic             w_load_next;
    logic             w_load_fst;
    logic             w_start;
    logic             w_clear;
    logic             w_pop;

    assign in_rdy       = (w_occ < CNT_W'(DEPTH));
    assign w_wr_en      = in_vld && in_rdy;
    assign w_cfg_len    = cfg_to_len(cfg_length);
    assign w_beat       = r_vld && stage_1_data_rdy;
    assign w_last       = w_beat && (r_rem == LEN_W'(1));
    assign w_occ_ge_len = (w_occ >= CNT_W'(w_cfg_len));
    // The word on the output still occupies its FIFO slot until its beat completes
    assign w_occ_gt_len = (w_occ >  CNT_W'(w_cfg_len));

    full_st1_data_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_data (in_data),
        .i_rd_en   (w_pop),
        .o_rd_head (w_head),
        .o_rd_next (w_next),
        .o_count   (w_occ)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_next = 1'b0;
        w_load_fst  = 1'b0;
        w_start     = 1'b0;
        w_clear     = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_occ_ge_len) begin
                    w_state_nxt = ST_SEND;
                    w_load      = 1'b1;
                    w_load_fst  = 1'b1;
                    w_start     = 1'b1;
                end
            end
            ST_SEND: begin
                if (w_beat) begin
                    w_pop = 1'b1;
                    if (!w_last) begin
                        w_load      = 1'b1;
                        w_load_next = 1'b1;
                    end else if (w_occ_gt_len) begin
                        w_load      = 1'b1;
                        w_load_next = 1'b1;
                        w_load_fst  = 1'b1;
                        w_start     = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_clear     = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
            r_fst  <= 1'b0;
            r_vld  <= 1'b0;
            r_rem  <= '0;
        end else begin
            if (w_load) begin
                r_data <= w_load_next ? w_next : w_head;
                r_fst  <= w_load_fst;
                r_vld  <= 1'b1;
            end else if (w_clear) begin
                r_fst  <= 1'b0;
                r_vld  <= 1'b0;
            end
            // Vector length is latched only here, so cfg_length edits wait for the next vector
            if (w_start) begin
                r_rem <= w_cfg_len;
            end else if (w_beat) begin
                r_rem <= r_rem - LEN_W'(1);
            end
        end
    end

    assign stage_1_data     = r_data;
    assign stage_1_data_fst = r_fst;
    assign stage_1_data_vld = r_vld;
    assign busy             = (r_state == ST_SEND);

`ifdef FULL_ST1_DATA_TX_CNT_EN
    logic [15:0] r_vec_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vec_cnt <= '0;
        end else if (w_last) begin
            r_vec_cnt <= r_vec_cnt + 16'd1;
        end
    end

    assign vec_count = r_vec_cnt;
`else
    assign vec_count = '0;
`endif

endmodule
